// File: rtl/l2_cache_data_array.sv
// l2_cache_data_array
//   Data storage for a 2-way set-associative cache: 2**INUM sets x 2 ways of
//   L21BUS-bit lines. The requester side reads and writes one L1CBUS word at a
//   time. The next level refills whole lines. The addressed line, as it stood
//   before any write in the same cycle, is presented for write-back.
//   Tag, LRU and sequencing live in the controller that drives
//   update/refill/way.
//
// Ports
//   clk               clock; all state changes on posedge
//   nrst              synchronous reset, active high
//   index_C_L1        set index
//   offset            byte offset in line; offset[5:2] selects the word
//   write_data_C_L1   word stored on update
//   read_data_L2_L1   refill line from the next level
//   update            write the selected word
//   refill            write the whole line (merged with the word if update)
//   way               way select for read, update and refill
//   read_data_L1_C    selected word of the post-write line, registered
//   write_data_L1_L2  selected line before the write (victim), registered

module l2_cache_data_array #(
   parameter int TNUM   = 18,
   parameter int INUM   = 26 - TNUM,
   parameter int L1CBUS = 32,
   parameter int L21BUS = 512
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [INUM-1:0]   index_C_L1,
   input  logic [5:0]        offset,
   input  logic [L1CBUS-1:0] write_data_C_L1,
   input  logic [L21BUS-1:0] read_data_L2_L1,
   input  logic              update,
   input  logic              refill,
   input  logic              way,
   output logic [L1CBUS-1:0] read_data_L1_C,
   output logic [L21BUS-1:0] write_data_L1_L2
);

   localparam int NSETS = 2 ** INUM;

   // The tag width only documents the address split; the datapath never uses it.
   localparam int unused_tag_w = TNUM;

   logic [L21BUS-1:0] mem_q [2][NSETS];

   logic [L1CBUS-1:0] read_word_d, read_word_q;
   logic [L21BUS-1:0] victim_line_d, victim_line_q;
   logic [L21BUS-1:0] line_old;
   logic [L21BUS-1:0] line_new;
   logic              wr_en;
   logic [3:0]        word_sel;
   logic [1:0]        unused_byte_sel;

   assign word_sel        = offset[5:2];
   assign unused_byte_sel = offset[1:0];

   always_comb begin
      line_old = mem_q[way][index_C_L1];
      wr_en    = refill | update;

      // On refill+update the incoming line is merged with the requester's
      // word, so a write-allocate completes in a single cycle.
      line_new = refill ? read_data_L2_L1 : line_old;
      if (update) begin
         line_new[word_sel*L1CBUS +: L1CBUS] = write_data_C_L1;
      end

      // The read returns the post-write word, so a write is visible
      // immediately. The victim is the pre-write line, which lets a refill
      // cycle also capture the line it evicts.
      read_word_d   = line_new[word_sel*L1CBUS +: L1CBUS];
      victim_line_d = line_old;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < NSETS; i++) begin
               mem_q[w][i] <= '0;
            end
         end
         read_word_q   <= '0;
         victim_line_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[way][index_C_L1] <= line_new;
         end
         read_word_q   <= read_word_d;
         victim_line_q <= victim_line_d;
      end
   end

   assign read_data_L1_C   = read_word_q;
   assign write_data_L1_L2 = victim_line_q;

endmodule

// File: tb/tb_l2_cache_data_array.sv
module tb_l2_cache_data_array;

   logic         clk;
   logic         nrst;
   logic [7:0]   index_C_L1;
   logic [5:0]   offset;
   logic [31:0]  write_data_C_L1;
   logic [511:0] read_data_L2_L1;
   logic         update;
   logic         refill;
   logic         way;
   logic [31:0]  read_data_L1_C;
   logic [511:0] write_data_L1_L2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference storage is kept as individual words, not as packed lines.
   logic [31:0] mdl [2][256][16];

   l2_cache_data_array dut (
      .clk              (clk),
      .nrst             (nrst),
      .index_C_L1       (index_C_L1),
      .offset           (offset),
      .write_data_C_L1  (write_data_C_L1),
      .read_data_L2_L1  (read_data_L2_L1),
      .update           (update),
      .refill           (refill),
      .way              (way),
      .read_data_L1_C   (read_data_L1_C),
      .write_data_L1_L2 (write_data_L1_L2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_line(input logic [31:0] base);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
      return l;
   endfunction

   function automatic logic [511:0] rnd_line();
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom();
      return l;
   endfunction

   // Drive one cycle, advance the model and compare both outputs after the edge.
   task automatic do_cycle(input string tag, input logic rst, input logic [7:0] idx,
                           input logic [5:0] off, input logic [31:0] wd,
                           input logic [511:0] line, input logic upd,
                           input logic rfl, input logic wy);
      logic [511:0] exp_victim;
      logic [31:0]  exp_word;
      nrst            = rst;
      index_C_L1      = idx;
      offset          = off;
      write_data_C_L1 = wd;
      read_data_L2_L1 = line;
      update          = upd;
      refill          = rfl;
      way             = wy;
      @(posedge clk);
      #1;
      if (rst) begin
         for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++)
               for (int k = 0; k < 16; k++) mdl[w][i][k] = '0;
         exp_victim = '0;
         exp_word   = '0;
      end else begin
         for (int k = 0; k < 16; k++) exp_victim[k*32 +: 32] = mdl[wy][idx][k];
         if (rfl)
            for (int k = 0; k < 16; k++) mdl[wy][idx][k] = line[k*32 +: 32];
         if (upd) mdl[wy][idx][off / 4] = wd;
         exp_word = mdl[wy][idx][off / 4];
      end
      chk({tag, "_word"}, {480'd0, read_data_L1_C}, {480'd0, exp_word});
      chk({tag, "_line"}, write_data_L1_L2, exp_victim);
   endtask

   task automatic rd(input string tag, input logic [7:0] idx, input logic [5:0] off,
                     input logic wy);
      do_cycle(tag, 1'b0, idx, off, '0, '0, 1'b0, 1'b0, wy);
   endtask

   initial begin
      logic [511:0] ln;
      logic [511:0] exp_line;
      nrst = 1'b1; index_C_L1 = '0; offset = '0; write_data_C_L1 = '0;
      read_data_L2_L1 = '0; update = 1'b0; refill = 1'b0; way = 1'b0;

      // Reset for 5 cycles, with write strobes high to show reset wins.
      for (int c = 0; c < 5; c++)
         do_cycle("rst", 1'b1, 8'h05, 6'h00, 32'hFFFF_FFFF, '1, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++)
         rd("rst_rd", 8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

      // Refill way0 idx 5, then word reads.
      do_cycle("t2_fill", 1'b0, 8'h05, 6'h00, '0, mk_line(32'h1000_0000), 1'b0, 1'b1, 1'b0);
      rd("t2_rd8", 8'h05, 6'h08, 1'b0);
      chk("t2_w2", {480'd0, read_data_L1_C}, {480'd0, 32'h1000_0002});
      rd("t2_rd3c", 8'h05, 6'h3C, 1'b0);
      chk("t2_w15", {480'd0, read_data_L1_C}, {480'd0, 32'h1000_000F});

      // Way isolation.
      do_cycle("t3_fill", 1'b0, 8'h05, 6'h00, '0, mk_line(32'h2000_0000), 1'b0, 1'b1, 1'b1);
      chk("t3_victim", write_data_L1_L2, '0);
      rd("t3_rd0", 8'h05, 6'h00, 1'b0);
      chk("t3_way0", {480'd0, read_data_L1_C}, {480'd0, 32'h1000_0000});
      rd("t3_rd1", 8'h05, 6'h00, 1'b1);
      chk("t3_way1", {480'd0, read_data_L1_C}, {480'd0, 32'h2000_0000});

      // Word update with write-first read and pre-write victim.
      do_cycle("t4_upd", 1'b0, 8'h05, 6'h10, 32'hDEAD_BEEF, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_bypass", {480'd0, read_data_L1_C}, {480'd0, 32'hDEAD_BEEF});
      chk("t4_pre_w4", {480'd0, write_data_L1_L2[4*32 +: 32]}, {480'd0, 32'h1000_0004});
      rd("t4_rd3", 8'h05, 6'h0C, 1'b0);
      chk("t4_w3", {480'd0, read_data_L1_C}, {480'd0, 32'h1000_0003});

      // Write-allocate merge.
      do_cycle("t5_merge", 1'b0, 8'h07, 6'h04, 32'hCAFE_F00D, mk_line(32'h3000_0000),
               1'b1, 1'b1, 1'b1);
      chk("t5_bypass", {480'd0, read_data_L1_C}, {480'd0, 32'hCAFE_F00D});
      rd("t5_rd", 8'h07, 6'h00, 1'b1);
      exp_line = mk_line(32'h3000_0000);
      exp_line[1*32 +: 32] = 32'hCAFE_F00D;
      chk("t5_line", write_data_L1_L2, exp_line);

      // Fill every line with random data, then read back every line.
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 256; i++) begin
            ln = rnd_line();
            do_cycle("t6_fill", 1'b0, 8'(i), 6'($urandom_range(0, 63)), '0, ln, 1'b0, 1'b1, 1'(w));
         end
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 256; i++)
            rd("t6_rd", 8'(i), 6'($urandom_range(0, 63)), 1'(w));

      // Random mixed traffic on a few sets to force hits and interactions.
      for (int c = 0; c < 2000; c++) begin
         ln = rnd_line();
         do_cycle("rnd", ($urandom_range(0, 99) == 0), 8'($urandom_range(0, 7)),
                  6'($urandom_range(0, 63)), $urandom(), ln,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
      end

      // One reset cycle clears the whole array.
      do_cycle("t6_rst", 1'b1, 8'h00, 6'h00, '0, '0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 256; i++)
            rd("t6_clr", 8'(i), 6'($urandom_range(0, 63)), 1'(w));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
